// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-port register file with a hardware clear sweep.
//
// Two write ports and NUM_RD combinational read ports. Write port 1 has
// priority over write port 0 when both target the same entry. Reset and the
// clear request do not zero the array directly. Instead, a sweep FSM writes
// zero to one entry per cycle for DEPTH cycles. While the sweep runs, busy is
// high, all writes are dropped and every read port returns zero.
//
// Parameters
//   DATA_W   : width of each entry
//   ADDR_W   : address width, DEPTH = 2**ADDR_W
//   NUM_RD   : number of read ports (1..4)
//   ZERO_REG : 1 -> entry 0 always reads 0 and is never written
//   BYPASS   : 1 -> same-cycle write data is forwarded to matching reads
//
// Ports
//   clk                    : rising-edge clock
//   reset                  : asynchronous active-high reset, starts a sweep
//   clear                  : request a clear sweep (ignored while busy)
//   busy                   : high while the clear sweep runs
//   we0/waddr0/wdata0      : write port 0
//   we1/waddr1/wdata1      : write port 1 (wins on same-address writes)
//   raddr                  : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata                  : packed read data, port k at [k*DATA_W +: DATA_W]
//   wr_conflict            : registered flag, one cycle after a same-address
//                            dual write that was not dropped
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    output logic                       busy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic                       wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   ptr_d;
    logic                wr_conflict_q;
    logic                wr_conflict_d;

    // Storage has no reset: it is zeroed only by the sweep.
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                drop0_s;
    logic                drop1_s;
    logic                we0_ok_s;
    logic                we1_ok_s;

    // A write counts only in RUN and, with ZERO_REG, not to entry 0.
    // Reset forces CLEAR asynchronously, so writes are also dropped while
    // reset is held.
    assign drop0_s  = (ZERO_REG == 1) && (waddr0 == {ADDR_W{1'b0}});
    assign drop1_s  = (ZERO_REG == 1) && (waddr1 == {ADDR_W{1'b0}});
    assign we0_ok_s = we0 && (state_q == ST_RUN) && !drop0_s;
    assign we1_ok_s = we1 && (state_q == ST_RUN) && !drop1_s;

    // Sweep FSM next-state and pointer logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_CLEAR;
                    ptr_d   = ptr_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_RUN;
                    ptr_d   = ptr_q;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Sweep FSM state and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Conflict flag: both ports active on the same surviving address.
    always_comb begin
        wr_conflict_d = we0_ok_s && we1_ok_s && (waddr0 == waddr1);
    end

    // Registered conflict flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Storage update: sweep zeroing, or port 0 then port 1 so port 1 wins.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[ptr_q] <= {DATA_W{1'b0}};
        end else begin
            if (we0_ok_s) begin
                mem_q[waddr0] <= wdata0;
            end
            if (we1_ok_s) begin
                mem_q[waddr1] <= wdata1;
            end
        end
    end

    assign busy        = (state_q == ST_CLEAR);
    assign wr_conflict = wr_conflict_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;

        assign ra_s = raddr[k*ADDR_W +: ADDR_W];

        // Read mux: busy and the zero register mask everything, then the
        // bypass (port 1 first), then the stored value.
        always_comb begin
            if (state_q == ST_CLEAR) begin
                rd_s = {DATA_W{1'b0}};
            end else if ((ZERO_REG == 1) && (ra_s == {ADDR_W{1'b0}})) begin
                rd_s = {DATA_W{1'b0}};
            end else if ((BYPASS == 1) && we1_ok_s && (waddr1 == ra_s)) begin
                rd_s = wdata1;
            end else if ((BYPASS == 1) && we0_ok_s && (waddr0 == ra_s)) begin
                rd_s = wdata0;
            end else begin
                rd_s = mem_q[ra_s];
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- directed testbench for regfile_mp.
// Three instances: u_a (defaults), u_b (BYPASS=0, shares u_a's inputs) and
// u_c (NUM_RD=4, ADDR_W=3, DATA_W=8). Inputs change 1 ns after the rising
// edge; combinational outputs are sampled 2 ns after that.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr;
    logic [63:0] rdata_a, rdata_b;
    logic        busy_a, busy_b, conf_a, conf_b;

    logic        c_we0, c_we1;
    logic [2:0]  c_waddr0, c_waddr1;
    logic [7:0]  c_wdata0, c_wdata1;
    logic [11:0] c_raddr;
    logic [31:0] c_rdata;
    logic        c_busy, c_conf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp u_a (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_a),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_a), .wr_conflict(conf_a)
    );

    regfile_mp #(.BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_b), .wr_conflict(conf_b)
    );

    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(4)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .busy(c_busy),
        .we0(c_we0), .waddr0(c_waddr0), .wdata0(c_wdata0),
        .we1(c_we1), .waddr1(c_waddr1), .wdata1(c_wdata1),
        .raddr(c_raddr), .rdata(c_rdata), .wr_conflict(c_conf)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] eb0;   // expected rd0, bypass instance
        logic [31:0] eb1;
        logic [31:0] en0;   // expected rd0, no-bypass instance
        logic [31:0] en1;
        logic        conf;  // expected wr_conflict after the edge
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count busy cycles of each instance until all are idle (bounded).
    task automatic wait_idle(output int na, output int nb, output int nc);
        int n;
        na = 0; nb = 0; nc = 0; n = 0;
        #2;
        while ((busy_a || busy_b || c_busy) && n < 200) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            if (c_busy) nc++;
            n++;
            @(posedge clk);
            #3;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; we1 = 1'b0; waddr0 = 5'd0; waddr1 = 5'd0;
        wdata0 = 32'd0; wdata1 = 32'd0; clear = 1'b0;
        c_we0 = 1'b0; c_we1 = 1'b0; c_waddr0 = 3'd0; c_waddr1 = 3'd0;
        c_wdata0 = 8'd0; c_wdata1 = 8'd0;
    endtask

    initial begin
        int na, nb, nc;

        //          we0  wa0    wd0            we1  wa1    wd1            ra0    ra1    eb0            eb1            en0            en1            conf
        vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0};
        vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0};
        vt[2]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  32'h22,       32'h22,       32'h0,        32'h0,        1'b1};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 32'h22,       32'hDEADBEEF, 1'b0};
        vt[4]  = '{1'b1, 5'd0,  32'h11,       1'b1, 5'd0,  32'h22,       5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h22,       32'h0,        32'h22,       1'b0};
        vt[6]  = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 32'hAA,       5'd10, 5'd9,  32'hAA,       32'h99,       32'h0,        32'h0,        1'b0};
        vt[7]  = '{1'b1, 5'd9,  32'h123,      1'b1, 5'd0,  32'h55,       5'd0,  5'd9,  32'h0,        32'h123,      32'h0,        32'h99,       1'b0};
        vt[8]  = '{1'b1, 5'd3,  32'hA5,       1'b0, 5'd0,  32'h0,        5'd3,  5'd9,  32'hA5,       32'h123,      32'h0,        32'h123,      1'b0};
        vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd10, 32'hA5,       32'hAA,       32'hA5,       32'hAA,       1'b0};
        vt[10] = '{1'b1, 5'd6,  32'h66,       1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd6,  32'hCAFEF00D, 32'h66,       32'hDEADBEEF, 32'h0,        1'b0};
        vt[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hCAFEF00D, 32'h66,       32'hCAFEF00D, 32'h66,       1'b0};

        // ---------------- reset and first sweep ----------------
        idle_inputs();
        raddr = 10'd0; c_raddr = 12'd0;
        reset = 1'b1;
        #2;
        chk("rst_busy_a", 64'(busy_a), 64'd1);
        chk("rst_conf_a", 64'(conf_a), 64'd0);
        chk("rst_busy_c", 64'(c_busy), 64'd1);
        step(); step(); step();
        reset = 1'b0;
        wait_idle(na, nb, nc);
        chk("sweep_len_a", 64'(na), 64'd32);
        chk("sweep_len_b", 64'(nb), 64'd32);
        chk("sweep_len_c", 64'(nc), 64'd8);

        for (int a = 0; a < 32; a++) begin
            raddr = {5'(31 - a), 5'(a)};
            #1;
            chk($sformatf("zero_a_p0_%0d", a), 64'(rdata_a[31:0]),  64'd0);
            chk($sformatf("zero_a_p1_%0d", a), 64'(rdata_a[63:32]), 64'd0);
            chk($sformatf("zero_b_p0_%0d", a), 64'(rdata_b[31:0]),  64'd0);
        end
        step();

        // ---------------- table-driven write/read/bypass ----------------
        for (int i = 0; i < 12; i++) begin
            we0 = vt[i].we0; waddr0 = vt[i].wa0; wdata0 = vt[i].wd0;
            we1 = vt[i].we1; waddr1 = vt[i].wa1; wdata1 = vt[i].wd1;
            raddr = {vt[i].ra1, vt[i].ra0};
            #2;
            chk($sformatf("v%0d_a_rd0", i), 64'(rdata_a[31:0]),  64'(vt[i].eb0));
            chk($sformatf("v%0d_a_rd1", i), 64'(rdata_a[63:32]), 64'(vt[i].eb1));
            chk($sformatf("v%0d_b_rd0", i), 64'(rdata_b[31:0]),  64'(vt[i].en0));
            chk($sformatf("v%0d_b_rd1", i), 64'(rdata_b[63:32]), 64'(vt[i].en1));
            step();
            chk($sformatf("v%0d_a_conf", i), 64'(conf_a), 64'(vt[i].conf));
            chk($sformatf("v%0d_b_conf", i), 64'(conf_b), 64'(vt[i].conf));
        end
        idle_inputs();

        // ---------------- clear sweep with dropped write and re-clear ----------------
        clear = 1'b1;
        step();
        clear = 1'b0;
        na = 0;
        while (busy_a && na < 100) begin
            na++;
            if (na == 10) begin
                we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hFF;
                we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hEE;
                raddr = {5'd7, 5'd3};
                #2;
                chk("sweep_rd_a_p0", 64'(rdata_a[31:0]),  64'd0);
                chk("sweep_rd_a_p1", 64'(rdata_a[63:32]), 64'd0);
                chk("sweep_rd_b_p0", 64'(rdata_b[31:0]),  64'd0);
            end
            if (na == 11) begin
                chk("sweep_conf_a", 64'(conf_a), 64'd0);
            end
            if (na == 20) begin
                clear = 1'b1;
            end
            step();
            we0 = 1'b0; we1 = 1'b0; clear = 1'b0;
        end
        chk("clear_len_a", 64'(na), 64'd32);
        wait_idle(na, nb, nc);
        raddr = {5'd9, 5'd3};
        #2;
        chk("after_clear_a_e3", 64'(rdata_a[31:0]),  64'd0);
        chk("after_clear_a_e9", 64'(rdata_a[63:32]), 64'd0);
        chk("after_clear_b_e3", 64'(rdata_b[31:0]),  64'd0);
        step();

        // ---------------- async reset clears conflict flag ----------------
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h1;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h2;
        step();
        idle_inputs();
        raddr = {5'd4, 5'd4};
        #1;
        chk("pre_rst_conf", 64'(conf_a), 64'd1);
        chk("pre_rst_e4", 64'(rdata_a[31:0]), 64'd2);
        reset = 1'b1;
        #1;
        chk("async_rst_conf", 64'(conf_a), 64'd0);
        chk("async_rst_busy", 64'(busy_a), 64'd1);
        chk("async_rst_rd", 64'(rdata_a[31:0]), 64'd0);
        step();
        reset = 1'b0;
        wait_idle(na, nb, nc);
        chk("rst2_len_a", 64'(na), 64'd32);
        raddr = {5'd4, 5'd4};
        #2;
        chk("rst2_e4", 64'(rdata_a[31:0]), 64'd0);
        step();

        // ---------------- reset at sweep cycle 17 ----------------
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 1; k < 17; k++) step();
        chk("mid_sweep_busy", 64'(busy_a), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_idle(na, nb, nc);
        chk("rst17_len_a", 64'(na), 64'd32);
        chk("rst17_len_b", 64'(nb), 64'd32);
        chk("rst17_len_c", 64'(nc), 64'd8);

        // ---------------- 4 read ports, narrow instance ----------------
        c_we0 = 1'b1; c_waddr0 = 3'd1; c_wdata0 = 8'h11;
        c_we1 = 1'b1; c_waddr1 = 3'd2; c_wdata1 = 8'h22;
        step();
        c_waddr0 = 3'd5; c_wdata0 = 8'h55;
        c_waddr1 = 3'd7; c_wdata1 = 8'h77;
        step();
        c_we0 = 1'b0; c_we1 = 1'b0;
        c_raddr = {3'd1, 3'd5, 3'd5, 3'd7};
        #2;
        chk("c_rd_p0", 64'(c_rdata[7:0]),   64'h77);
        chk("c_rd_p1", 64'(c_rdata[15:8]),  64'h55);
        chk("c_rd_p2", 64'(c_rdata[23:16]), 64'h55);
        chk("c_rd_p3", 64'(c_rdata[31:24]), 64'h11);
        c_raddr = {3'd3, 3'd2, 3'd0, 3'd2};
        #1;
        chk("c_rd2_p0", 64'(c_rdata[7:0]),   64'h22);
        chk("c_rd2_p1", 64'(c_rdata[15:8]),  64'h00);
        chk("c_rd2_p2", 64'(c_rdata[23:16]), 64'h22);
        chk("c_rd2_p3", 64'(c_rdata[31:24]), 64'h00);
        step();
        c_we0 = 1'b1; c_waddr0 = 3'd6; c_wdata0 = 8'h0A;
        c_we1 = 1'b1; c_waddr1 = 3'd6; c_wdata1 = 8'h0B;
        c_raddr = {3'd6, 3'd6, 3'd6, 3'd6};
        #2;
        chk("c_byp_p0", 64'(c_rdata[7:0]),   64'h0B);
        chk("c_byp_p3", 64'(c_rdata[31:24]), 64'h0B);
        step();
        c_we0 = 1'b0; c_we1 = 1'b0;
        #1;
        chk("c_conf", 64'(c_conf), 64'd1);
        chk("c_e6", 64'(c_rdata[15:8]), 64'h0B);
        step();
        chk("c_conf_off", 64'(c_conf), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
